exponent_add_pipe: RTL and testbench
====================================

EXPONENT_ADD_PIPE -- requirements
Module: exponent_add_pipe

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 5, number of register stages from accepted input to output (range 1..8).
REQ-002 SHALL have port CLK  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-006 SHALL have port A  input  32  IEEE-754 single operand A.
REQ-007 SHALL have port B  input  32  IEEE-754 single operand B.
REQ-008 SHALL have port out_valid  output  1  Ez_add/Sz/flags valid.
REQ-009 SHALL have port out_ready  input  1  downstream (exponent update stage) consumes result.
REQ-010 SHALL have port Ez_add  output  10  biased product exponent, two's complement.
REQ-011 SHALL have port Sz  output  1  product sign.
REQ-012 SHALL have port zero_f, inf_f, nan_f  output  1 each  special-operand flags.

Function
REQ-013 SHALL compute Ez_add = {2'b00,EA} + {2'b00,EB} - 10'd127, modulo 2^10; EA/EB = exponent field, or 1 when field is 0 (denormal/zero).
REQ-014 SHALL produce range -125..381; bit 9 set means negative (underflow side), bit 8 set with bit 9 clear means overflow side.
REQ-015 SHALL compute Sz = A[31] XOR B[31].
REQ-016 SHALL accept a transfer when in_valid && in_ready; result appears at out_valid exactly PIPE_DEPTH cycles later absent stalls.
REQ-017 SHALL carry a per-stage valid bit; bubbles (in_valid=0) propagate as invalid stages.
REQ-018 SHALL stall globally: stall = out_valid && !out_ready; while stalled no stage register updates and in_ready = 0.
REQ-019 SHALL drive in_ready = !stall combinationally (no dependency on in_valid).
REQ-020 SHALL hold Ez_add, Sz, flags stable while out_valid && !out_ready.
REQ-021 SHALL sustain one result per cycle with out_ready held 1 (full throughput, no overflow of internal state).
REQ-022 SHALL never drop or duplicate a transfer; order preserved.
REQ-023 SHALL, when out_ready rises during a stall, advance all stages and accept new input in that same cycle.

Reset
REQ-024 SHALL on RST=0 asynchronously clear all stage valid bits; out_valid=0, Ez_add=0, Sz=0, zero_f=inf_f=nan_f=0.
REQ-025 SHALL discard all in-flight operands on reset mid-operation; first result after release only from a post-reset transfer.
REQ-026 SHALL drive in_ready=1 during and after reset (no stall possible when out_valid=0).

Configuration
REQ-027 SHALL support macro EXP_SPECIAL_DETECT_EN.
REQ-028 SHALL, with EXP_SPECIAL_DETECT_EN defined: nan_f = either operand NaN or (inf x zero); inf_f = any inf and not nan_f; zero_f = any zero and not nan_f; flags pipelined alongside Ez_add.
REQ-029 SHALL, without EXP_SPECIAL_DETECT_EN: zero_f, inf_f, nan_f tied 0, no flag registers; Ez_add/Sz unchanged.

Verification
REQ-030 SHALL verify A=0x3F800000, B=0x40000000 (1.0x2.0), out_ready=1 -> after 5 cycles out_valid=1, Ez_add=10'd128, Sz=0.
REQ-031 SHALL verify A=0x7F000000, B=0x7F000000 -> Ez_add=10'd381 (0x17D), bit8=1, bit9=0.
REQ-032 SHALL verify A=0x00800000, B=0x80800000 -> Ez_add=10'h383 (-125), Sz=1.
REQ-033 SHALL verify 8 back-to-back inputs, out_ready low cycles 7-9 -> in_ready=0 for those cycles, outputs held, all 8 results delivered in order, none lost.
REQ-034 SHALL verify with EXP_SPECIAL_DETECT_EN: A=0x7F800000, B=0x00000000 -> nan_f=1, inf_f=0, zero_f=0; A=0x7F800000, B=0x3F800000 -> inf_f=1.
REQ-035 SHALL verify RST pulsed low with 3 operands in flight -> out_valid=0 immediately, no stale result emerges after release.

Source files
------------

// File: rtl/exponent_add_pipe.sv
// ---------------------------------------------------------------------------
// exponent_add_pipe
//
// Exponent/sign front end of an IEEE-754 single-precision multiplier.
// Adds the biased exponents of A and B, removes one bias, and produces the
// product sign. The result travels through PIPE_DEPTH register stages with
// a valid/ready handshake on both sides and a single global stall.
//
// Parameters
//   PIPE_DEPTH  register stages from accepted input to output (1..8)
//
// Ports
//   CLK        clock, all state on the rising edge
//   RST        asynchronous active-low reset
//   in_valid   operand pair present on A/B
//   in_ready   pair is accepted this cycle (low only while stalled)
//   A, B       IEEE-754 single operands
//   out_valid  Ez_add/Sz/flags hold a result
//   out_ready  downstream consumes the result this cycle
//   Ez_add     biased product exponent, 10-bit two's complement
//              (bit 9 = underflow side, bit 8 with bit 9 clear = overflow)
//   Sz         product sign
//   zero_f, inf_f, nan_f  special-operand flags
//
// Build option
//   EXP_SPECIAL_DETECT_EN  when defined, zero/inf/nan flags are derived and
//                          pipelined with the exponent; otherwise they are 0.
// ---------------------------------------------------------------------------
module exponent_add_pipe #(
  parameter int PIPE_DEPTH = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  Ez_add,
  output logic        Sz,
  output logic        zero_f,
  output logic        inf_f,
  output logic        nan_f
);

  localparam int LAST = PIPE_DEPTH - 1;

  // Denormals and zero use an effective exponent of 1. The sum is taken
  // modulo 2^10 so results below zero wrap into the upper half.
  function automatic logic signed [9:0] exp_add(input logic [7:0] ea_fld,
                                                input logic [7:0] eb_fld);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = (ea_fld == 8'd0) ? 8'd1 : ea_fld;
    eb = (eb_fld == 8'd0) ? 8'd1 : eb_fld;
    return signed'({2'b00, ea} + {2'b00, eb} - 10'd127);
  endfunction

`ifdef EXP_SPECIAL_DETECT_EN
  // Returns {nan, inf, zero}. inf x zero is an invalid product, so it is
  // reported as NaN and the inf/zero flags are suppressed whenever NaN wins.
  function automatic logic [2:0] special_flags(input logic [31:0] a,
                                               input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic nan, inf, zero;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    inf  = (a_inf || b_inf) && !nan;
    zero = (a_zero || b_zero) && !nan;
    return {nan, inf, zero};
  endfunction
`endif

  logic               stall;
  logic               adv;
  logic signed [9:0]  ez_in;
  logic               sz_in;

  logic               vld_p [PIPE_DEPTH];
  logic signed [9:0]  ez_p  [PIPE_DEPTH];
  logic               sz_p  [PIPE_DEPTH];

  // The whole pipe freezes while the last stage holds an unconsumed result;
  // any bubble inside the pipe is not squeezed out.
  assign stall    = vld_p[LAST] && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  assign ez_in = exp_add(A[30:23], B[30:23]);
  assign sz_in = A[31] ^ B[31];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < PIPE_DEPTH; i++) vld_p[i] <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < PIPE_DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // ---- stage 0 .. PIPE_DEPTH-1: exponent/sign payload ----
  always_ff @(posedge CLK) begin
    if (adv) begin
      ez_p[0] <= ez_in;
      sz_p[0] <= sz_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        ez_p[i] <= ez_p[i-1];
        sz_p[i] <= sz_p[i-1];
      end
    end
  end

  // Payload registers are not reset; gating with the last valid bit gives
  // zeroed outputs during/after reset and for bubbles.
  assign out_valid = vld_p[LAST];
  assign Ez_add    = out_valid ? ez_p[LAST] : 10'd0;
  assign Sz        = out_valid && sz_p[LAST];

`ifdef EXP_SPECIAL_DETECT_EN
  logic [2:0] fl_in;
  logic [2:0] fl_p [PIPE_DEPTH];

  assign fl_in = special_flags(A, B);

  // ---- flag stages, aligned with the payload stages ----
  always_ff @(posedge CLK) begin
    if (adv) begin
      fl_p[0] <= fl_in;
      for (int i = 1; i < PIPE_DEPTH; i++) fl_p[i] <= fl_p[i-1];
    end
  end

  assign nan_f  = out_valid && fl_p[LAST][2];
  assign inf_f  = out_valid && fl_p[LAST][1];
  assign zero_f = out_valid && fl_p[LAST][0];
`else
  // Mantissas only matter for special-value detection.
  logic unused_mant;
  assign unused_mant = ^{A[22:0], B[22:0]};

  assign nan_f  = 1'b0;
  assign inf_f  = 1'b0;
  assign zero_f = 1'b0;
`endif

endmodule

// File: tb/tb_exponent_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_exponent_add_pipe
//
// Directed bench for exponent_add_pipe (PIPE_DEPTH = 5). Inputs change 1 time
// unit after a rising edge; outputs are sampled in the same window.
// ---------------------------------------------------------------------------
module tb_exponent_add_pipe;

  localparam int LAT = 5;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  Ez_add;
  logic        Sz;
  logic        zero_f;
  logic        inf_f;
  logic        nan_f;

  int nvec;
  int nfail;

  logic [9:0] last_ez;
  logic [9:0] exp_ez [8];
  logic       exp_sz [8];
  int         rd;
  int         wr;

  exponent_add_pipe #(.PIPE_DEPTH(LAT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Ez_add    (Ez_add),
    .Sz        (Sz),
    .zero_f    (zero_f),
    .inf_f     (inf_f),
    .nan_f     (nan_f)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated transfer: checks the result is absent one cycle early,
  // present exactly LAT cycles after presentation, and not repeated.
  // fl = {nan, inf, zero} expected with special detection enabled.
  task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [9:0] ez, input logic sz, input logic [2:0] fl);
    out_ready = 1'b1;
    A = a;
    B = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (LAT - 2) step();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ez"}, 32'(Ez_add), 32'(ez));
    chk({tag, "_sz"}, 32'(Sz), 32'(sz));
`ifdef EXP_SPECIAL_DETECT_EN
    chk({tag, "_flags"}, 32'({nan_f, inf_f, zero_f}), 32'(fl));
`else
    chk({tag, "_flags"}, 32'({nan_f, inf_f, zero_f}), 32'd0);
`endif
    last_ez = Ez_add;
    step();
    chk({tag, "_once"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    nvec      = 0;
    nfail     = 0;
    RST       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 32'd0;
    B         = 32'd0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ez", 32'(Ez_add), 32'd0);
    chk("rst_sz", 32'(Sz), 32'd0);
    chk("rst_flags", 32'({nan_f, inf_f, zero_f}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    RST = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors
    run_single("one_x_two",  32'h3F800000, 32'h40000000, 10'd128, 1'b0, 3'b000);
    run_single("big_x_big",  32'h7F000000, 32'h7F000000, 10'h17D, 1'b0, 3'b000);
    chk("big_bit8", 32'(last_ez[8]), 32'd1);
    chk("big_bit9", 32'(last_ez[9]), 32'd0);
    run_single("min_x_nmin", 32'h00800000, 32'h80800000, 10'h383, 1'b1, 3'b000);
    chk("min_bit9", 32'(last_ez[9]), 32'd1);
    run_single("zero_x_one", 32'h00000000, 32'h3F800000, 10'd1,   1'b0, 3'b001);
    run_single("inf_x_zero", 32'h7F800000, 32'h00000000, 10'd129, 1'b0, 3'b100);
    run_single("inf_x_one",  32'h7F800000, 32'h3F800000, 10'd255, 1'b0, 3'b010);
    run_single("nan_x_neg",  32'h7FC00000, 32'hBF800000, 10'd255, 1'b1, 3'b100);
    run_single("neg_x_neg",  32'hC0000000, 32'hC0400000, 10'd129, 1'b0, 3'b000);

    // Eight back-to-back transfers, out_ready low in cycles 7..9.
    // Vector i: exponents 100+i and 50+3i -> Ez = 23+4i; signs i[0], i[1].
    for (int i = 0; i < 8; i++) begin
      exp_ez[i] = 10'(23 + 4 * i);
      exp_sz[i] = i[0] ^ i[1];
    end
    rd = 0;
    wr = 0;
    for (int c = 0; c < 30 && rd < 8; c++) begin
      out_ready = !(c >= 7 && c <= 9);
      in_valid  = (wr < 8);
      if (wr < 8) begin
        A = {wr[0], 8'(100 + wr), 23'h0};
        B = {wr[1], 8'(50 + 3 * wr), 23'h0};
      end
      #1;
      if (c >= 7 && c <= 9) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (c == 10) chk("resume_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        chk("burst_ez", 32'(Ez_add), 32'(exp_ez[rd]));
        chk("burst_sz", 32'(Sz), 32'(exp_sz[rd]));
        if (out_ready) rd++;
      end
      if (in_valid && in_ready) wr++;
      @(posedge CLK);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("burst_delivered", 32'(rd), 32'd8);
    chk("burst_accepted", 32'(wr), 32'd8);
    step();
    chk("burst_no_extra", 32'(out_valid), 32'd0);

    // Reset with three operands in flight, the oldest stalled at the output
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      A = {1'b0, 8'(120 + k), 23'h0};
      B = 32'h3F800000;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("flight_out_valid", 32'(out_valid), 32'd1);
    chk("flight_in_ready", 32'(in_ready), 32'd0);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ez", 32'(Ez_add), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    RST = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    run_single("after_rst", 32'h3F800000, 32'h40000000, 10'd128, 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
